// File: rtl/proc_fl_in_fifo.sv
// proc_fl_in_fifo: per-channel input FIFOs feeding the FP processor read port,
// with sticky underflow flags and a registered, maskable interrupt request.
module proc_fl_in_fifo #(
  parameter int NBMANT = 16,
  parameter int NBEXPO = 6,
  parameter int NUIOIN = 2,
  parameter int FDEPTH = 4,
  parameter logic [NUIOIN-1:0] ITRMSK = '0,
  localparam int NBW = NBMANT + NBEXPO + 1,
  localparam int AW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int PW = $clog2(FDEPTH),
  localparam int CW = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUIOIN*NBW-1:0]   src_data,
  input  logic [NUIOIN-1:0]       src_valid,
  output logic [NUIOIN-1:0]       src_ready,
  input  logic [AW-1:0]           addr_in,
  input  logic                    req_in,
  output logic [NBW-1:0]          io_in,
  output logic [NUIOIN-1:0]       fifo_empty,
  output logic [NUIOIN-1:0]       uflow,
  input  logic [NUIOIN-1:0]       uflow_clr,
  output logic                    itr
);
  localparam logic [CW-1:0] FULL = CW'(FDEPTH);
  logic [PW-1:0] rp_q [NUIOIN];
  logic [PW-1:0] rp_d [NUIOIN];
  logic [PW-1:0] wp_q [NUIOIN];
  logic [PW-1:0] wp_d [NUIOIN];
  logic [CW-1:0] cnt_q [NUIOIN];
  logic [CW-1:0] cnt_d [NUIOIN];
  logic [NBW-1:0] mem [NUIOIN][FDEPTH];
  logic [NUIOIN-1:0] uflow_q, uflow_d, push, pop, rd;
  logic itr_q, itr_d;
  logic [AW:0] addr_x;

  always_comb begin
    addr_x = {1'b0, addr_in};
    io_in = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      src_ready[i] = cnt_q[i] != FULL;
      fifo_empty[i] = cnt_q[i] == '0;
      rd[i] = req_in && addr_x == (AW+1)'(i);
      push[i] = src_valid[i] && src_ready[i];
      pop[i] = rd[i] && !fifo_empty[i];
      wp_d[i] = wp_q[i] + PW'(push[i]);
      rp_d[i] = rp_q[i] + PW'(pop[i]);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      // a fresh underflow wins over a same-cycle clear
      uflow_d[i] = (rd[i] && fifo_empty[i]) || (uflow_q[i] && !uflow_clr[i]);
      io_in = (addr_x == (AW+1)'(i) && !fifo_empty[i]) ? mem[i][rp_q[i]] : io_in;
    end
    itr_d = |(~fifo_empty & ITRMSK);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUIOIN; i++)
      if (push[i]) mem[i][wp_q[i]] <= src_data[i*NBW +: NBW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_q <= '{default: '0};
      wp_q <= '{default: '0};
      cnt_q <= '{default: '0};
      uflow_q <= '0;
      itr_q <= 1'b0;
    end else begin
      rp_q <= rp_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      uflow_q <= uflow_d;
      itr_q <= itr_d;
    end
  end

  assign uflow = uflow_q;
  assign itr = itr_q;
endmodule

// File: doc/proc_fl_in_fifo.md
Name: proc_fl_in_fifo

Overview:
Input-side buffer bank for the floating-point processor. It accepts words from NUIOIN independent producers over valid/ready handshakes and queues each in its own FIFO. The processor pops words with its addr_in/req_in/io_in read port. It also raises a registered interrupt request when any unmasked channel holds data.

Parameters:
NBMANT, 16, mantissa width; word width NBW = NBMANT+NBEXPO+1
NBEXPO, 6, exponent width
NUIOIN, 2, number of input channels / processor input addresses
FDEPTH, 4, words per channel FIFO; power of two, >= 2
ITRMSK, 0, NUIOIN-bit mask; bit i=1 lets channel i raise itr

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
src_data  input  NUIOIN*NBW  producer words; channel i at bits [i*NBW +: NBW]
src_valid  input  NUIOIN  producer word valid, per channel
src_ready  output  NUIOIN  FIFO can accept, per channel
addr_in  input  $clog2(NUIOIN)  processor read address (channel select)
req_in  input  1  processor read strobe; pops the selected channel
io_in  output  NBW  head word of the selected channel, to the processor
fifo_empty  output  NUIOIN  per-channel empty flag
uflow  output  NUIOIN  sticky underflow flag, per channel
uflow_clr  input  NUIOIN  clears the matching uflow bits
itr  output  1  interrupt request to the processor

Behaviour:
- Reset (rst=0, asynchronous): all pointers and counts = 0; src_ready = all ones; fifo_empty = all ones; uflow = 0; itr = 0; FIFO contents are don't-care. Reset mid-transfer discards all queued words.
- Per channel i: read pointer rp, write pointer wp (log2 FDEPTH bits, wrap mod FDEPTH), count cnt (0..FDEPTH, log2(FDEPTH)+1 bits).
- src_ready[i] = (cnt < FDEPTH), decoded from registered cnt only. There is no combinational path from req_in to src_ready.
- Push: src_valid[i] & src_ready[i] writes src_data slice at wp, then wp++. Data written while ready is low is ignored; the producer holds it.
- io_in is combinational: mem_i[rp] of the channel selected by addr_in.
  - io_in = 0 if that channel is empty or addr_in >= NUIOIN.
  - Valid in the same cycle req_in is asserted, for the processor's sampling.
- Pop: req_in & addr_in == i & cnt != 0 advances rp by 1 on the clock edge.
- Empty read: req_in on an empty channel returns 0, does not move the pointers, and sets uflow[i] on the next edge.
- Out-of-range addr_in: returns 0, no pop, no flag change.
- Simultaneous push and pop on one channel: both take effect and cnt is unchanged.
  - If full, push is refused (ready=0) and the pop proceeds.
  - If empty, there is no bypass: the pop is an underflow and the pushed word is stored, making cnt=1.
- Visibility latency: a pushed word appears on io_in and clears fifo_empty one cycle after the push edge.
- uflow: set has priority over uflow_clr in the same cycle; it is cleared only by uflow_clr or reset.
- fifo_empty[i] = (cnt == 0), registered-derived.
- itr: registered, itr <= |(~fifo_empty & ITRMSK). It goes high one cycle after an unmasked channel becomes non-empty and low one cycle after it drains.
- No state machine beyond the per-channel pointer/count registers. All channels run independently and concurrently.

Test Plan:
- Reset then idle -> src_ready=2'b11, fifo_empty=2'b11, io_in=0, uflow=0, itr=0.
- Push 0x000001..0x000004 on ch0 (FDEPTH=4) -> src_ready[0]=0 after the 4th push edge. Fifth word 0x000005 held with valid=1 is not taken. Pops with addr_in=0 return 1,2,3,4 in order; ready reasserts after the first pop and word 5 is accepted.
- Ch0 empty, req_in with addr_in=0 -> io_in=0, uflow[0]=1 next cycle, pointers unchanged. uflow_clr[0]=1 one cycle later clears it. Same-cycle underflow and uflow_clr leave uflow[0]=1.
- Full ch1 with push and pop in the same cycle -> pop returns the head, push refused, cnt goes 4 to 3. Empty ch1 with push 0x00ABCD and pop in the same cycle -> io_in=0, uflow[1]=1, next cycle io_in=0x00ABCD.
- ITRMSK=2'b10: push to ch0 only -> itr stays 0. Push to ch1 -> itr=1 one cycle after fifo_empty[1] falls; popping ch1 empty -> itr=0 one cycle later.
- Assert rst low asynchronously with ch0 holding 3 words -> outputs return to reset values immediately, without waiting for a clock edge. After release, the first pop underflows.
